// File: rtl/alu_sequencer.sv
// alu_sequencer: command-driven initiator for an external combinational ALU.
// It accepts one command at a time. A command either loads an immediate into
// a 4-entry register file or issues one ALU operation on two registers. Each
// result is written back and returned on a valid/ready response channel.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake
//   cmd_load                 1 = load immediate, 0 = execute ALU op
//   cmd_opcode, cmd_cin      ALU controls for exec commands
//   cmd_srca, cmd_srcb       source register indices
//   cmd_dst                  destination register index
//   cmd_imm                  immediate for loads
//   alu_a, alu_b             registered operands driven to the ALU
//   alu_cin, alu_opcode      registered controls driven to the ALU
//   alu_result, alu_zero     ALU outputs, sampled at the end of ISSUE
//   rsp_valid / rsp_ready    response handshake
//   rsp_data, rsp_zero       written-back value and its zero flag
//   err                      sticky flag: ALU zero output disagreed with result
module alu_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_opcode,
  input  logic             cmd_cin,
  input  logic [1:0]       cmd_srca,
  input  logic [1:0]       cmd_srcb,
  input  logic [1:0]       cmd_dst,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rf_q [4];
  logic [WIDTH-1:0] rf_d [4];
  logic [1:0]       dst_q, dst_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_cin_q, alu_cin_d;
  logic [2:0]       alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             err_q, err_d;
  logic             cmd_fire;

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign cmd_fire  = cmd_valid && cmd_ready;

  always_comb begin
    state_d      = state_q;
    rf_d         = rf_q;
    dst_d        = dst_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cin_d    = alu_cin_q;
    alu_opcode_d = alu_opcode_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;
    err_d        = err_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_load) begin
            rf_d[cmd_dst] = cmd_imm;
            rsp_data_d    = cmd_imm;
            rsp_zero_d    = (cmd_imm == '0);
            state_d       = RESP;
          end else begin
            alu_a_d      = rf_q[cmd_srca];
            alu_b_d      = rf_q[cmd_srcb];
            alu_opcode_d = cmd_opcode;
            alu_cin_d    = cmd_cin;
            dst_d        = cmd_dst;
            state_d      = ISSUE;
          end
        end
      end
      ISSUE: begin
        // ALU is combinational: its outputs are valid by the end of this cycle.
        rf_d[dst_q] = alu_result;
        rsp_data_d  = alu_result;
        rsp_zero_d  = alu_zero;
        if (alu_zero != (alu_result == '0)) begin
          err_d = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int unsigned i = 0; i < 4; i++) begin
        rf_q[i] <= '0;
      end
      dst_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      alu_opcode_q <= '0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_q         <= rf_d;
      dst_q        <= dst_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cin_q    <= alu_cin_d;
      alu_opcode_q <= alu_opcode_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
      err_q        <= err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cin    = alu_cin_q;
  assign alu_opcode = alu_opcode_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_zero   = rsp_zero_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small combinational ALU model.
// ALU opcodes: 000 A+cin, 001 A+B+cin, 010 A+~B+cin, 011 A-1+cin,
// 100 AND, 101 OR, 110 XOR, 111 ~A. alu_fault makes the model also report
// zero for a result of 4.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_load = 1'b0;
  logic [2:0] cmd_opcode = '0;
  logic       cmd_cin = 1'b0;
  logic [1:0] cmd_srca = '0;
  logic [1:0] cmd_srcb = '0;
  logic [1:0] cmd_dst = '0;
  logic [3:0] cmd_imm = '0;
  logic [3:0] alu_a, alu_b;
  logic       alu_cin;
  logic [2:0] alu_opcode;
  logic [3:0] alu_result;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_data;
  logic       rsp_zero;
  logic       err;
  logic       alu_fault = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_opcode(cmd_opcode), .cmd_cin(cmd_cin), .cmd_srca(cmd_srca),
    .cmd_srcb(cmd_srcb), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .err(err)
  );

  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      3'b000:  alu_result = alu_a + {3'b000, alu_cin};
      3'b001:  alu_result = alu_a + alu_b + {3'b000, alu_cin};
      3'b010:  alu_result = alu_a + ~alu_b + {3'b000, alu_cin};
      3'b011:  alu_result = alu_a - 4'd1 + {3'b000, alu_cin};
      3'b100:  alu_result = alu_a & alu_b;
      3'b101:  alu_result = alu_a | alu_b;
      3'b110:  alu_result = alu_a ^ alu_b;
      default: alu_result = ~alu_a;
    endcase
    alu_zero = (alu_result == 4'd0) || (alu_fault && alu_result == 4'd4);
  end

  // Drives one command, waits for the handshake and then for rsp_valid.
  // lat = edges from the accepting edge's cycle until rsp_valid is seen.
  task automatic send_cmd(input logic load, input logic [2:0] op, input logic cin,
                          input logic [1:0] sa, input logic [1:0] sb,
                          input logic [1:0] dst, input logic [3:0] imm,
                          output int lat, output logic ok);
    int wait_cnt = 0;
    while (!cmd_ready && wait_cnt < 20) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    cmd_load = load; cmd_opcode = op; cmd_cin = cin;
    cmd_srca = sa; cmd_srcb = sb; cmd_dst = dst; cmd_imm = imm;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = rsp_valid && (wait_cnt < 20);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %0b want 0", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    checks++; if (rsp_data !== 4'h0 || rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp got %h/%0b want 0/0", rsp_data, rsp_zero); end
    checks++; if (alu_a !== 4'h0 || alu_b !== 4'h0) begin errors++; $display("FAIL reset_alu_ab got %h/%h want 0/0", alu_a, alu_b); end
    checks++; if (alu_opcode !== 3'd0 || alu_cin !== 1'b0) begin errors++; $display("FAIL reset_alu_ctl got %0d/%0b want 0/0", alu_opcode, alu_cin); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err); end
    // rsp_ready while nothing is pending must not disturb anything
    rsp_ready = 1'b1;
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %0b want 1", cmd_ready); end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_rsp_ready got valid %0b ready %0b want 0 1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_load_add();
    int lat; logic ok;
    send_cmd(1'b1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd1, 4'd5, lat, ok);
    checks++; if (!ok || lat != 1) begin errors++; $display("FAIL load_r1_latency got %0d want 1", lat); end
    checks++; if (rsp_data !== 4'd5 || rsp_zero !== 1'b0) begin errors++; $display("FAIL load_r1_data got %h/%0b want 5/0", rsp_data, rsp_zero); end
    take_rsp();
    send_cmd(1'b1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd2, 4'd3, lat, ok);
    checks++; if (!ok || lat != 1) begin errors++; $display("FAIL load_r2_latency got %0d want 1", lat); end
    checks++; if (rsp_data !== 4'd3) begin errors++; $display("FAIL load_r2_data got %h want 3", rsp_data); end
    take_rsp();
    send_cmd(1'b0, 3'b001, 1'b0, 2'd1, 2'd2, 2'd3, 4'd0, lat, ok);
    checks++; if (!ok || lat != 2) begin errors++; $display("FAIL add_latency got %0d want 2", lat); end
    checks++; if (rsp_data !== 4'd8 || rsp_zero !== 1'b0) begin errors++; $display("FAIL add_data got %h/%0b want 8/0", rsp_data, rsp_zero); end
    checks++; if (alu_a !== 4'd5 || alu_b !== 4'd3 || alu_opcode !== 3'b001) begin errors++; $display("FAIL add_alu_ops got %h/%h/%0d want 5/3/1", alu_a, alu_b, alu_opcode); end
    take_rsp();
  endtask

  task automatic test_same_src();
    int lat; logic ok;
    send_cmd(1'b0, 3'b010, 1'b1, 2'd1, 2'd1, 2'd2, 4'd0, lat, ok);
    checks++; if (!ok || rsp_data !== 4'd0 || rsp_zero !== 1'b1) begin errors++; $display("FAIL sub_self got %h/%0b want 0/1", rsp_data, rsp_zero); end
    checks++; if (alu_a !== 4'd5 || alu_b !== 4'd5 || alu_cin !== 1'b1) begin errors++; $display("FAIL sub_self_ops got %h/%h/%0b want 5/5/1", alu_a, alu_b, alu_cin); end
    take_rsp();
    // read r2 back through a pass-through op
    send_cmd(1'b0, 3'b000, 1'b0, 2'd2, 2'd2, 2'd2, 4'd0, lat, ok);
    checks++; if (!ok || rsp_data !== 4'd0 || alu_a !== 4'd0) begin errors++; $display("FAIL sub_self_wb got %h/%h want 0/0", rsp_data, alu_a); end
    take_rsp();
  endtask

  task automatic test_wrap();
    int lat; logic ok;
    send_cmd(1'b1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 4'hF, lat, ok);
    checks++; if (!ok || rsp_data !== 4'hF || rsp_zero !== 1'b0) begin errors++; $display("FAIL load_r0 got %h/%0b want F/0", rsp_data, rsp_zero); end
    take_rsp();
    send_cmd(1'b0, 3'b000, 1'b1, 2'd0, 2'd0, 2'd0, 4'd0, lat, ok);
    checks++; if (!ok || rsp_data !== 4'h0 || rsp_zero !== 1'b1) begin errors++; $display("FAIL inc_wrap got %h/%0b want 0/1", rsp_data, rsp_zero); end
    take_rsp();
    send_cmd(1'b0, 3'b011, 1'b0, 2'd0, 2'd0, 2'd0, 4'd0, lat, ok);
    checks++; if (!ok || rsp_data !== 4'hF || rsp_zero !== 1'b0) begin errors++; $display("FAIL dec_wrap got %h/%0b want F/0", rsp_data, rsp_zero); end
    take_rsp();
  endtask

  task automatic test_backpressure();
    // r1=5 + r3=8 -> 13 into r3
    cmd_load = 1'b0; cmd_opcode = 3'b001; cmd_cin = 1'b0;
    cmd_srca = 2'd1; cmd_srcb = 2'd3; cmd_dst = 2'd3;
    cmd_valid = 1'b1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_start_ready got %0b want 1", cmd_ready); end
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_issue got ready %0b valid %0b want 0 0", cmd_ready, rsp_valid); end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 4'hD || rsp_zero !== 1'b0 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d got valid %0b data %h ready %0b want 1 D 0", i, rsp_valid, rsp_data, cmd_ready);
      end
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got ready %0b valid %0b want 1 0", cmd_ready, rsp_valid); end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat; logic ok;
    cmd_load = 1'b0; cmd_opcode = 3'b001; cmd_cin = 1'b0;
    cmd_srca = 2'd1; cmd_srcb = 2'd2; cmd_dst = 2'd3;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL midrst_state got valid %0b ready %0b want 0 0", rsp_valid, cmd_ready); end
    checks++; if (alu_a !== 4'd0 || alu_b !== 4'd0 || rsp_data !== 4'd0) begin errors++; $display("FAIL midrst_regs got %h/%h/%h want 0/0/0", alu_a, alu_b, rsp_data); end
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %0b want 1", cmd_ready); end
    send_cmd(1'b0, 3'b001, 1'b0, 2'd1, 2'd2, 2'd1, 4'd0, lat, ok);
    checks++; if (!ok || rsp_data !== 4'd0 || alu_a !== 4'd0 || alu_b !== 4'd0) begin errors++; $display("FAIL midrst_rf12 got %h/%h/%h want 0/0/0", rsp_data, alu_a, alu_b); end
    take_rsp();
    send_cmd(1'b0, 3'b101, 1'b0, 2'd3, 2'd0, 2'd2, 4'd0, lat, ok);
    checks++; if (!ok || rsp_data !== 4'd0 || rsp_zero !== 1'b1) begin errors++; $display("FAIL midrst_rf30 got %h/%0b want 0/1", rsp_data, rsp_zero); end
    take_rsp();
  endtask

  task automatic test_err();
    int lat; logic ok;
    alu_fault = 1'b1;
    send_cmd(1'b1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd1, 4'd4, lat, ok);
    checks++; if (!ok || err !== 1'b0 || rsp_zero !== 1'b0) begin errors++; $display("FAIL err_load got err %0b zero %0b want 0 0", err, rsp_zero); end
    take_rsp();
    send_cmd(1'b0, 3'b000, 1'b0, 2'd1, 2'd1, 2'd2, 4'd0, lat, ok);
    checks++; if (!ok || err !== 1'b1) begin errors++; $display("FAIL err_set got %0b want 1", err); end
    checks++; if (rsp_data !== 4'd4 || rsp_zero !== 1'b1) begin errors++; $display("FAIL err_rsp got %h/%0b want 4/1", rsp_data, rsp_zero); end
    take_rsp();
    send_cmd(1'b1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd2, 4'd7, lat, ok);
    take_rsp();
    send_cmd(1'b0, 3'b001, 1'b0, 2'd1, 2'd2, 2'd3, 4'd0, lat, ok);
    checks++; if (!ok || rsp_data !== 4'hB || err !== 1'b1) begin errors++; $display("FAIL err_sticky got data %h err %0b want B 1", rsp_data, err); end
    take_rsp();
    alu_fault = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %0b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_same_src();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
